kgp_ctrl_fsm: RTL and testbench
===============================

# kgp_ctrl_fsm

Multi-cycle control sequencer for the KGP-RISC core. Steps each instruction through fetch, decode, execute, memory and write-back. Classifies the opcode produced by the instruction decoder and drives the enables for the instruction register, ALU, data memory, register file and PC. Sits between the decoder and the datapath, with ready-based handshakes to instruction and data memory.

## Interface
- HALT_OPCODE, 6'b111111, opcode that stops the core
- MEM_TIMEOUT, 16, max cycles to wait for dmem_ready before faulting (≥1)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  leave IDLE and begin fetching
- opcode  in  6  decoder opcode field, valid in DECODE
- branch_taken  in  1  branch condition from flag logic, valid in EXEC
- imem_ready  in  1  instruction word available
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- ir_load  out  1  load instruction register
- alu_en  out  1  ALU / flag update enable
- dmem_rd  out  1  data memory read
- dmem_wr  out  1  data memory write
- reg_wr  out  1  register file write
- wb_sel  out  1  0 = ALU result, 1 = memory data
- pc_load  out  1  update PC
- pc_sel  out  2  00 = PC+4, 01 = PC+imm2, 10 = label
- halted  out  1  HALT state reached
- fault  out  1  data memory timeout
- instr_count  out  32  retired-instruction counter

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR. Outputs are Moore-decoded from the state and the latched opcode op_q.
- Opcode classes (op_q):
  - 001110 lw
  - 001111 sw
  - 010000 addi
  - 010001 comi
  - 0110xx conditional branch
  - 011100 jump
  - HALT_OPCODE halt
  - all others: R-type ALU
- IDLE: all outputs 0. start=1 → FETCH.
- FETCH: imem_req=1, held until imem_ready. When imem_ready=1: ir_load=1 in that same cycle, then → DECODE.
- DECODE: op_q <= opcode.
  - If opcode = HALT_OPCODE → HALT.
  - Otherwise → EXEC.
- EXEC: alu_en=1 for exactly one cycle; branch_taken is sampled into br_q.
  - lw/sw → MEM.
  - All others → WB.
- MEM: dmem_rd=1 (lw) or dmem_wr=1 (sw), held until dmem_ready.
  - Wait counter clears on MEM entry and increments each cycle dmem_ready=0.
  - dmem_ready=1 → WB, even on the same cycle the counter reaches MEM_TIMEOUT.
  - Counter reaching MEM_TIMEOUT with dmem_ready=0 → ERROR.
- WB: pc_load=1 for one cycle; instr_count += 1 (wraps at 2^32); then → FETCH.
  - reg_wr=1 for R-type, addi, lw.
  - reg_wr=0 for comi, sw, branch, jump.
  - wb_sel=1 only for lw.
  - pc_sel=10 for jump; 01 for branch with br_q=1; 00 otherwise.
- HALT: halted=1; no requests issued; start ignored; exits only on rst.
- ERROR: fault=1; no requests issued; start ignored; exits only on rst.
- imem_ready outside FETCH and dmem_ready outside MEM are ignored.

## Timing
- Reset, asynchronous and mid-operation included: state=IDLE, op_q=0, br_q=0, wait counter=0, instr_count=0, all outputs 0. Any in-progress memory request drops immediately.
- Latency from FETCH entry, assuming zero-wait memory:
  - ALU, addi, comi, branch, jump: 4 cycles (FETCH, DECODE, EXEC, WB).
  - lw, sw: 5 cycles.
  - Each imem/dmem wait cycle adds one cycle.
- start to first imem_req: 1 cycle.
- dmem_rd/dmem_wr rise on MEM entry and fall the cycle after dmem_ready is seen.
- pc_load and ir_load are never asserted in the same cycle.
- At most one of imem_req, dmem_rd, dmem_wr is high at any time.

## Test plan
- ALU instruction: rst, start, opcode 000000, imem_ready always 1 → imem_req/ir_load in cycle 1, alu_en in cycle 3, reg_wr=1, wb_sel=0, pc_sel=00, pc_load in cycle 4; instr_count=1.
- lw with dmem_ready delayed 3 cycles: dmem_rd high for 4 cycles, then WB with reg_wr=1, wb_sel=1. Same for sw: dmem_wr high, reg_wr=0.
- Branch opcode 011000:
  - branch_taken=1 in EXEC → pc_sel=01 in WB.
  - branch_taken=0 → pc_sel=00.
  - Jump 011100 → pc_sel=10, reg_wr=0.
- MEM_TIMEOUT=4, lw with dmem_ready held 0 → ERROR after 4 MEM cycles: fault=1, dmem_rd=0, no further imem_req.
- HALT_OPCODE fetched → halted=1 after DECODE; start pulses ignored; instr_count unchanged.
- rst asserted mid-MEM (dmem_wr=1) → all outputs 0 asynchronously, instr_count=0; after rst release, start restarts at FETCH.

Source files
------------

// File: rtl/kgp_ctrl_if.sv
// Handshake and control bundle between the KGP-RISC control sequencer and the
// decoder/datapath/memory side.
interface kgp_ctrl_if;
    logic        start;
    logic [5:0]  opcode;
    logic        branch_taken;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        ir_load;
    logic        alu_en;
    logic        dmem_rd;
    logic        dmem_wr;
    logic        reg_wr;
    logic        wb_sel;
    logic        pc_load;
    logic [1:0]  pc_sel;
    logic        halted;
    logic        fault;
    logic [31:0] instr_count;

    modport master (
        output start, opcode, branch_taken, imem_ready, dmem_ready,
        input  imem_req, ir_load, alu_en, dmem_rd, dmem_wr, reg_wr, wb_sel,
               pc_load, pc_sel, halted, fault, instr_count
    );

    modport slave (
        input  start, opcode, branch_taken, imem_ready, dmem_ready,
        output imem_req, ir_load, alu_en, dmem_rd, dmem_wr, reg_wr, wb_sel,
               pc_load, pc_sel, halted, fault, instr_count
    );
endinterface

// File: rtl/kgp_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/memory/write-back sequencer for KGP-RISC.
// Outputs are registered from the next state so they track the state exactly.
module kgp_ctrl_fsm #(
    parameter logic [5:0] HALT_OPCODE = 6'b111111,
    parameter int         MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    kgp_ctrl_if.slave  io_ctl
);
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERROR
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [5:0]      r_op;
    logic            r_br;
    logic [WCW-1:0]  r_wait;
    logic [31:0]     r_count;

    logic            r_imem_req;
    logic            r_alu_en;
    logic            r_dmem_rd;
    logic            r_dmem_wr;
    logic            r_reg_wr;
    logic            r_wb_sel;
    logic            r_pc_load;
    logic [1:0]      r_pc_sel;
    logic            r_halted;
    logic            r_fault;

    logic w_is_lw, w_is_sw, w_is_addi, w_is_comi, w_is_br, w_is_jmp, w_is_halt, w_is_rtype;
    logic w_br_next;
    logic w_wait_hit;

    assign w_is_lw    = (r_op == 6'b001110);
    assign w_is_sw    = (r_op == 6'b001111);
    assign w_is_addi  = (r_op == 6'b010000);
    assign w_is_comi  = (r_op == 6'b010001);
    assign w_is_br    = (r_op[5:2] == 4'b0110);
    assign w_is_jmp   = (r_op == 6'b011100);
    assign w_is_halt  = (r_op == HALT_OPCODE);
    assign w_is_rtype = !(w_is_lw || w_is_sw || w_is_addi || w_is_comi ||
                          w_is_br || w_is_jmp || w_is_halt);

    // WB outputs are registered on the EXEC->WB edge, before br_q has loaded.
    assign w_br_next  = (r_state == S_EXEC) ? io_ctl.branch_taken : r_br;
    assign w_wait_hit = (int'(r_wait) + 1) >= MEM_TIMEOUT;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (io_ctl.start) w_state_next = S_FETCH;
            S_FETCH:  if (io_ctl.imem_ready) w_state_next = S_DECODE;
            S_DECODE: w_state_next = (io_ctl.opcode == HALT_OPCODE) ? S_HALT : S_EXEC;
            S_EXEC:   w_state_next = (w_is_lw || w_is_sw) ? S_MEM : S_WB;
            S_MEM: begin
                if (io_ctl.dmem_ready)  w_state_next = S_WB;
                else if (w_wait_hit)    w_state_next = S_ERROR;
            end
            S_WB:     w_state_next = S_FETCH;
            S_HALT:   w_state_next = S_HALT;
            S_ERROR:  w_state_next = S_ERROR;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_br       <= 1'b0;
            r_wait     <= '0;
            r_count    <= '0;
            r_imem_req <= 1'b0;
            r_alu_en   <= 1'b0;
            r_dmem_rd  <= 1'b0;
            r_dmem_wr  <= 1'b0;
            r_reg_wr   <= 1'b0;
            r_wb_sel   <= 1'b0;
            r_pc_load  <= 1'b0;
            r_pc_sel   <= 2'b00;
            r_halted   <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_DECODE) r_op <= io_ctl.opcode;
            if (r_state == S_EXEC)   r_br <= io_ctl.branch_taken;
            if (r_state != S_MEM)
                r_wait <= '0;
            else if (!io_ctl.dmem_ready)
                r_wait <= r_wait + 1'b1;
            if (r_state == S_WB) r_count <= r_count + 32'd1;

            r_imem_req <= (w_state_next == S_FETCH);
            r_alu_en   <= (w_state_next == S_EXEC);
            r_dmem_rd  <= (w_state_next == S_MEM) && w_is_lw;
            r_dmem_wr  <= (w_state_next == S_MEM) && w_is_sw;
            r_reg_wr   <= (w_state_next == S_WB) && (w_is_rtype || w_is_addi || w_is_lw);
            r_wb_sel   <= (w_state_next == S_WB) && w_is_lw;
            r_pc_load  <= (w_state_next == S_WB);
            if (w_state_next != S_WB)      r_pc_sel <= 2'b00;
            else if (w_is_jmp)             r_pc_sel <= 2'b10;
            else if (w_is_br && w_br_next) r_pc_sel <= 2'b01;
            else                           r_pc_sel <= 2'b00;
            r_halted   <= (w_state_next == S_HALT);
            r_fault    <= (w_state_next == S_ERROR);
        end
    end

    // ir_load follows imem_ready in the same FETCH cycle so no extra cycle is lost.
    assign io_ctl.ir_load     = r_imem_req && io_ctl.imem_ready;
    assign io_ctl.imem_req    = r_imem_req;
    assign io_ctl.alu_en      = r_alu_en;
    assign io_ctl.dmem_rd     = r_dmem_rd;
    assign io_ctl.dmem_wr     = r_dmem_wr;
    assign io_ctl.reg_wr      = r_reg_wr;
    assign io_ctl.wb_sel      = r_wb_sel;
    assign io_ctl.pc_load     = r_pc_load;
    assign io_ctl.pc_sel      = r_pc_sel;
    assign io_ctl.halted      = r_halted;
    assign io_ctl.fault       = r_fault;
    assign io_ctl.instr_count = r_count;
endmodule

// File: tb/tb_kgp_ctrl_fsm.sv
// Scoreboard bench for kgp_ctrl_fsm: stimulus queues expected write-back and
// memory-strobe records, a negedge monitor pops and compares them.
module tb_kgp_ctrl_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kgp_ctrl_if bus ();

    kgp_ctrl_fsm #(
        .HALT_OPCODE (6'b111111),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_ctl (bus)
    );

    typedef struct {
        logic [5:0] op;
        logic       br;
        int         iwait;
        int         dwait;
        logic       reg_wr;
        logic       wb_sel;
        logic [1:0] pc_sel;
        int         lat;
        int         alu_at;
        int         mkind;
        int         mlen;
    } vec_t;

    typedef struct {
        logic       reg_wr;
        logic       wb_sel;
        logic [1:0] pc_sel;
        int         cnt;
        int         lat;
        int         alu_at;
    } wb_exp_t;

    typedef struct {
        int kind;
        int len;
    } mem_exp_t;

    wb_exp_t  wbq[$];
    mem_exp_t memq[$];
    vec_t     vecs[12];

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic logic [11:0] outs();
        return {bus.imem_req, bus.ir_load, bus.alu_en, bus.dmem_rd, bus.dmem_wr,
                bus.reg_wr, bus.wb_sel, bus.pc_load, bus.pc_sel, bus.halted, bus.fault};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    int   m_lat = 0, m_alu_at = 0, m_alu_cnt = 0, m_mem_len = 0, m_mem_kind = 0, m_wb_n = 0;
    logic m_prev_imem = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            m_lat = 0; m_alu_cnt = 0; m_alu_at = 0; m_mem_len = 0; m_prev_imem = 1'b0;
        end else begin
            if (bus.imem_req && !m_prev_imem) begin
                m_lat = 1; m_alu_cnt = 0; m_alu_at = 0;
            end else if (m_lat != 0) begin
                m_lat++;
            end
            if (bus.alu_en) begin
                m_alu_cnt++; m_alu_at = m_lat;
            end
            chk("excl", 32'(int'(bus.imem_req) + int'(bus.dmem_rd) + int'(bus.dmem_wr) > 1
                        || (bus.pc_load && bus.ir_load)), 32'd0);
            if (bus.dmem_rd || bus.dmem_wr) begin
                m_mem_len++;
                m_mem_kind = bus.dmem_rd ? 1 : 2;
            end else if (m_mem_len > 0) begin
                if (memq.size() == 0) begin
                    timeout_fail("mem_unexpected");
                end else begin
                    mem_exp_t me;
                    me = memq.pop_front();
                    chk("mem_kind", 32'(m_mem_kind), 32'(me.kind));
                    chk("mem_len",  32'(m_mem_len),  32'(me.len));
                    $display("mem strobe kind=%0d len=%0d (exp %0d/%0d)", m_mem_kind, m_mem_len, me.kind, me.len);
                end
                m_mem_len = 0;
            end
            if (bus.pc_load) begin
                if (wbq.size() == 0) begin
                    timeout_fail("wb_unexpected");
                end else begin
                    wb_exp_t e;
                    e = wbq.pop_front();
                    chk("reg_wr",  32'(bus.reg_wr),   32'(e.reg_wr));
                    chk("wb_sel",  32'(bus.wb_sel),   32'(e.wb_sel));
                    chk("pc_sel",  32'(bus.pc_sel),   32'(e.pc_sel));
                    chk("count",   bus.instr_count,   32'(e.cnt));
                    chk("latency", 32'(m_lat),        32'(e.lat));
                    chk("alu_at",  32'(m_alu_at),     32'(e.alu_at));
                    chk("alu_cnt", 32'(m_alu_cnt),    32'd1);
                    $display("wb #%0d reg_wr=%0b wb_sel=%0b pc_sel=%0b cnt=%0d lat=%0d alu_at=%0d",
                             m_wb_n, bus.reg_wr, bus.wb_sel, bus.pc_sel, bus.instr_count, m_lat, m_alu_at);
                    m_wb_n++;
                end
            end
            m_prev_imem = bus.imem_req;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_imem_req();
        int k = 0;
        while (!bus.imem_req && k < 12) begin cycle(); k++; end
        if (!bus.imem_req) timeout_fail("imem_req_wait");
    endtask

    task automatic fetch(input logic [5:0] op, input logic br, input int iwait);
        wait_imem_req();
        repeat (iwait) cycle();
        bus.opcode = op;
        bus.branch_taken = br;
        bus.imem_ready = 1'b1;
        cycle();
        bus.imem_ready = 1'b0;
    endtask

    task automatic wait_strobe();
        int k = 0;
        while (!(bus.dmem_rd || bus.dmem_wr) && k < 12) begin cycle(); k++; end
        if (!(bus.dmem_rd || bus.dmem_wr)) timeout_fail("strobe_wait");
    endtask

    task automatic run_vec(input vec_t v);
        wb_exp_t e;
        int k = 0;
        e.reg_wr = v.reg_wr; e.wb_sel = v.wb_sel; e.pc_sel = v.pc_sel;
        e.cnt = exp_count; e.lat = v.lat; e.alu_at = v.alu_at;
        wbq.push_back(e);
        if (v.mkind != 0) memq.push_back('{kind: v.mkind, len: v.mlen});
        fetch(v.op, v.br, v.iwait);
        if (v.mkind != 0) begin
            wait_strobe();
            repeat (v.dwait) cycle();
            bus.dmem_ready = 1'b1;
            cycle();
            bus.dmem_ready = 1'b0;
        end
        while (!bus.pc_load && k < 12) begin cycle(); k++; end
        if (!bus.pc_load) timeout_fail("pc_load_wait");
        exp_count++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        exp_count = 0;
        chk("reset_outs", 32'(outs()), 32'd0);
        chk("reset_count", bus.instr_count, 32'd0);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        chk("start_imem_req", 32'(bus.imem_req), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.opcode = 6'd0; bus.branch_taken = 1'b0;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;

        //          op        br iw dw  reg wb pc     lat alu mk ml
        vecs[0]  = '{6'b000000, 0, 0, 0, 1, 0, 2'b00, 4, 3, 0, 0};
        vecs[1]  = '{6'b001110, 0, 0, 3, 1, 1, 2'b00, 8, 3, 1, 4};
        vecs[2]  = '{6'b001111, 0, 0, 3, 0, 0, 2'b00, 8, 3, 2, 4};
        vecs[3]  = '{6'b011000, 1, 0, 0, 0, 0, 2'b01, 4, 3, 0, 0};
        vecs[4]  = '{6'b011000, 0, 0, 0, 0, 0, 2'b00, 4, 3, 0, 0};
        vecs[5]  = '{6'b011100, 1, 0, 0, 0, 0, 2'b10, 4, 3, 0, 0};
        vecs[6]  = '{6'b010000, 0, 0, 0, 1, 0, 2'b00, 4, 3, 0, 0};
        vecs[7]  = '{6'b010001, 1, 0, 0, 0, 0, 2'b00, 4, 3, 0, 0};
        vecs[8]  = '{6'b101010, 1, 2, 0, 1, 0, 2'b00, 6, 5, 0, 0};
        vecs[9]  = '{6'b001110, 0, 0, 0, 1, 1, 2'b00, 5, 3, 1, 1};
        vecs[10] = '{6'b011011, 1, 0, 0, 0, 0, 2'b01, 4, 3, 0, 0};
        vecs[11] = '{6'b001111, 1, 0, 1, 0, 0, 2'b00, 6, 3, 2, 2};

        do_reset();
        do_start();
        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Reset asserted mid-MEM while a store is outstanding
        fetch(6'b001111, 1'b0, 0);
        wait_strobe();
        chk("midmem_wr", 32'(bus.dmem_wr), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_outs", 32'(outs()), 32'd0);
        chk("async_rst_count", bus.instr_count, 32'd0);
        cycle();
        rst = 1'b0;
        exp_count = 0;
        do_start();
        run_vec(vecs[0]);

        // Data memory never answers: ERROR after four MEM cycles
        memq.push_back('{kind: 1, len: 4});
        fetch(6'b001110, 1'b0, 0);
        wait_strobe();
        begin
            int k = 0;
            while (!bus.fault && k < 12) begin cycle(); k++; end
            if (!bus.fault) timeout_fail("fault_wait");
        end
        chk("error_outs", 32'(outs()), 32'h001);
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
        repeat (3) cycle();
        chk("error_sticky_outs", 32'(outs()), 32'h001);
        chk("error_count", bus.instr_count, 32'(exp_count));

        // HALT opcode: halted after DECODE, start ignored, count frozen
        do_reset();
        do_start();
        run_vec(vecs[6]);
        fetch(6'b111111, 1'b0, 0);
        cycle();
        chk("halt_outs", 32'(outs()), 32'h002);
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
        repeat (3) cycle();
        chk("halt_sticky_outs", 32'(outs()), 32'h002);
        chk("halt_count", bus.instr_count, 32'(exp_count));

        do_reset();
        repeat (3) cycle();
        chk("wbq_empty", 32'(wbq.size()), 32'd0);
        chk("memq_empty", 32'(memq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
